expr_serializer: RTL and testbench

Transmit-side counterpart of the expression recognizer. Takes a parallel description of an arithmetic expression (decimal digits joined by `+` / `*`) and emits it as an ASCII byte stream, one character per accepted transfer. The stream uses the same 8-bit character format the recognizer consumes, so the two blocks can be chained for loopback testing. A valid/ready handshake lets a downstream consumer stall the stream.

---
 rtl/expr_pkg.sv | 19 +
 rtl/expr_char_enc.sv | 40 ++++
 rtl/expr_serializer.sv | 119 +++++++++++
 tb/tb_expr_serializer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared definitions for the expression serializer and recognizer.
// ASCII character codes, operator encoding and FSM states.
package expr_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_NUL  = 8'h00;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FIN
  } state_t;

endpackage

// File: rtl/expr_char_enc.sv
// Maps character index k to its ASCII code.
// Even k selects a digit, odd k selects an operator.
module expr_char_enc
  import expr_pkg::*;
#(
  parameter int MAX_OPND = 8,
  parameter int KW       = 4,
  parameter int OW       = 7
) (
  input  logic [KW-1:0]         k,
  input  logic [4*MAX_OPND-1:0] digits,
  input  logic [OW-1:0]         ops,
  output logic [7:0]            ch
);

  logic [KW-1:0] idx;
  logic [3:0]    dig;
  logic          op;

  assign idx = k >> 1;

  always_comb begin
    dig = 4'h0;
    op  = OP_ADD;
    for (int i = 0; i < MAX_OPND; i++)
      if (int'(idx) == i) dig = digits[4*i +: 4];
    for (int i = 0; i < OW; i++)
      if (int'(idx) == i) op = ops[i];
  end

  always_comb begin
    ch = CH_NUL;
    unique case (1'b1)
      !k[0]:              ch = CH_ZERO + {4'h0, dig};
      k[0] && op == OP_MUL: ch = CH_MUL;
      default:            ch = CH_PLUS;
    endcase
  end

endmodule

// File: rtl/expr_serializer.sv
// Serializes a parallel digit/operator expression into ASCII
// characters over a valid/ready stream; all outputs registered.
module expr_serializer
  import expr_pkg::*;
#(
  parameter int MAX_OPND = 8,
  parameter int CW       = $clog2(MAX_OPND + 1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [CW-1:0]          opnd_cnt,
  input  logic [4*MAX_OPND-1:0]  digits,
  input  logic [(MAX_OPND > 1 ? MAX_OPND-1 : 1)-1:0] ops,
  output logic [7:0]             ch,
  output logic                   ch_valid,
  input  logic                   ch_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int OW = (MAX_OPND > 1) ? MAX_OPND - 1 : 1;
  localparam int KW = (MAX_OPND > 1) ? $clog2(2 * MAX_OPND) : 1;

  state_t                state, state_nxt;
  logic [KW-1:0]         k, k_nxt, k_last;
  logic                  req, take, bad, err_d;
  logic [CW-1:0]         n_r;
  logic [4*MAX_OPND-1:0] dig_r;
  logic [OW-1:0]         ops_r;
  logic [7:0]            enc_ch, ch_d;

  // Request is latched first and validated from registers next cycle.
  assign take   = (state == IDLE) && !req && start;
  assign k_last = KW'((int'(n_r) << 1) - 2);

  always_comb begin
    bad = (n_r == '0) || (int'(n_r) > MAX_OPND);
    for (int i = 0; i < MAX_OPND; i++)
      if (i < int'(n_r) && dig_r[4*i +: 4] > 4'd9) bad = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    err_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (bad) begin
            err_d = 1'b1;
          end else begin
            state_nxt = SEND;
            k_nxt     = '0;
          end
        end
      end
      SEND: begin
        if (ch_valid && ch_ready) begin
          if (k == k_last) state_nxt = FIN;
          else             k_nxt     = k + 1'b1;
        end
      end
      FIN: begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end
    endcase
  end

  expr_char_enc #(
    .MAX_OPND (MAX_OPND),
    .KW       (KW),
    .OW       (OW)
  ) u_enc (
    .k      (k_nxt),
    .digits (dig_r),
    .ops    (ops_r),
    .ch     (enc_ch)
  );

  assign ch_d = (state_nxt == SEND) ? enc_ch : CH_NUL;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      k        <= '0;
      req      <= 1'b0;
      n_r      <= '0;
      dig_r    <= '0;
      ops_r    <= '0;
      ch       <= CH_NUL;
      ch_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      req      <= take;
      if (take) begin
        n_r   <= opnd_cnt;
        dig_r <= digits;
        ops_r <= ops;
      end
      ch       <= ch_d;
      ch_valid <= (state_nxt == SEND);
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == FIN);
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_expr_serializer.sv
// Bench for expr_serializer: directed and random requests
// compared against a character-queue reference model.
module tb_expr_serializer;

  localparam int MAX = 8;
  localparam int CW  = $clog2(MAX + 1);

  logic            clk = 1'b0;
  logic            clr;
  logic            start;
  logic [CW-1:0]   opnd_cnt;
  logic [4*MAX-1:0] digits;
  logic [MAX-2:0]  ops;
  logic [7:0]      ch;
  logic            ch_valid;
  logic            ch_ready;
  logic            busy;
  logic            done;
  logic            err;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  expr_serializer #(.MAX_OPND(MAX)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .opnd_cnt (opnd_cnt),
    .digits   (digits),
    .ops      (ops),
    .ch       (ch),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: text of the expression as a list of characters.
  task automatic build(input int n, input logic [31:0] d,
                       input logic [6:0] o, output bit ok);
    ok = (n >= 1) && (n <= MAX);
    exp_q.delete();
    for (int i = 0; i < n && i < MAX; i++) begin
      if (d[4*i +: 4] > 4'd9) ok = 1'b0;
      exp_q.push_back(8'h30 + 8'(d[4*i +: 4]));
      if (i < n - 1) exp_q.push_back(o[i] ? 8'h2A : 8'h2B);
    end
  endtask

  task automatic pulse_start(input int n, input logic [31:0] d,
                             input logic [6:0] o);
    @(posedge clk); #1;
    start    = 1'b1;
    opnd_cnt = CW'(n);
    digits   = d;
    ops      = o;
    ch_ready = 1'b0;
    @(posedge clk); #1;
    start    = 1'b0;
    opnd_cnt = CW'($urandom);
    digits   = $urandom;
    ops      = 7'($urandom);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 2nd and 4th offers
  task automatic send(input int n, input logic [31:0] d,
                      input logic [6:0] o, input int mode,
                      input bit poke);
    bit ok, r, st;
    int j, cyc;
    build(n, d, o, ok);
    pulse_start(n, d, o);
    @(negedge clk);
    chk("lat_valid", ch_valid, 0);
    chk("lat_busy", busy, 0);
    chk("lat_err", err, 0);
    if (!ok) begin
      @(negedge clk);
      chk("rej_err", err, 1);
      chk("rej_busy", busy, 0);
      chk("rej_valid", ch_valid, 0);
      chk("rej_done", done, 0);
      @(negedge clk);
      chk("rej_err_off", err, 0);
      chk("rej_busy2", busy, 0);
      chk("rej_valid2", ch_valid, 0);
      return;
    end
    j = 0; cyc = 0; st = 1'b0;
    while (j < exp_q.size() && cyc < 200) begin
      @(negedge clk);
      cyc++;
      chk("ch_valid", ch_valid, 1);
      chk("ch", ch, exp_q[j]);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("err_send", err, 0);
      if (poke && j == 1) begin
        start    = 1'b1;
        opnd_cnt = CW'(1);
        digits   = $urandom;
        ops      = 7'($urandom);
      end else begin
        start = 1'b0;
      end
      unique case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = !((j == 1 || j == 3) && !st);
      endcase
      ch_ready = r;
      if (r) begin
        j++;
        st = 1'b0;
      end else begin
        st = 1'b1;
      end
    end
    chk("timeout", j, exp_q.size());
    @(negedge clk);
    ch_ready = 1'b0;
    start    = 1'b0;
    chk("done", done, 1);
    chk("done_busy", busy, 1);
    chk("done_valid", ch_valid, 0);
    chk("done_ch", ch, 0);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("idle_valid", ch_valid, 0);
    chk("idle_busy2", busy, 0);
  endtask

  function automatic logic [31:0] rand_digits(input bool_bad);
    logic [31:0] d;
    for (int i = 0; i < MAX; i++)
      d[4*i +: 4] = (bool_bad && $urandom_range(0, 15) == 0)
                    ? 4'hB : 4'($urandom_range(0, 9));
    return d;
  endfunction

  initial begin
    bit ok;
    clr      = 1'b0;
    start    = 1'b0;
    opnd_cnt = '0;
    digits   = '0;
    ops      = '0;
    ch_ready = 1'b0;
    #12;
    chk("rst_ch", ch, 0);
    chk("rst_valid", ch_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    clr = 1'b1;

    send(3, 32'h221, 7'b10, 0, 1'b0);
    send(3, 32'h221, 7'b10, 2, 1'b0);
    send(1, 32'h9, 7'b0, 0, 1'b0);
    send(0, 32'h0, 7'b0, 0, 1'b0);
    send(3, 32'h2A1, 7'b01, 0, 1'b0);
    send(9, 32'h1234_5678, 7'h55, 0, 1'b0);
    send(2, 32'hFFFF_FF21, 7'h7F, 0, 1'b0);
    send(8, 32'h9999_9999, 7'h2A, 1, 1'b0);
    send(4, rand_digits(0), 7'($urandom), 0, 1'b1);

    // Reset in the middle of an n=4 stream.
    build(4, 32'h7351, 7'b101, ok);
    pulse_start(4, 32'h7351, 7'b101);
    ch_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_ch", ch, exp_q[2]);
    #2 clr = 1'b0;
    #1;
    chk("mid_rst_ch", ch, 0);
    chk("mid_rst_valid", ch_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk);
    clr = 1'b1;
    ch_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    send(4, 32'h7351, 7'b101, 0, 1'b0);

    for (int t = 0; t < 25; t++)
      send($urandom_range(0, 9), rand_digits(1), 7'($urandom),
           1, 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

endmodule
